// File: rtl/fica_pkg.sv
// Shared types and constants for the FastICA convergence control path.
// Holds the element format, the matrix size and the controller state encoding.
package fica_pkg;

    localparam int DATA_W = 26;
    localparam int FRAC_W = 13;
    localparam int N_ELEM = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_WAIT,
        S_SCAN,
        S_DECIDE,
        S_DONE
    } conv_state_t;

    typedef logic signed [DATA_W-1:0] fx_t;

endpackage

// File: rtl/fica_conv_ctrl.sv
// Convergence controller: triggers the error-abs stage, scans the 16 magnitudes
// against a tolerance through one comparator, then commits W and decides the run outcome.
module fica_conv_ctrl #(
    parameter int DATA_W   = 26,
    parameter int N_ELEM   = 16,
    parameter int ABS_LAT  = 1,
    parameter int MAX_ITER = 64,
    parameter int ITER_W   = 7
) (
    input  logic                     clk_conv,
    input  logic                     rst_conv,
    input  logic                     start,
    input  logic                     clr,
    input  logic [DATA_W-1:0]        tol,
    input  logic [N_ELEM*DATA_W-1:0] abs_flat,
    output logic                     en_abs,
    output logic                     busy,
    output logic                     w_load,
    output logic                     next_iter,
    output logic                     done,
    output logic                     converged,
    output logic                     timeout,
    output logic [ITER_W-1:0]        iter_cnt,
    output logic [3:0]               err_idx
);
    import fica_pkg::*;

    localparam int IDX_W  = 4;
    localparam int WAIT_W = (ABS_LAT < 2) ? 1 : $clog2(ABS_LAT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_ELEM - 1);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);

    conv_state_t              state;
    logic [IDX_W-1:0]         idx;
    logic [WAIT_W-1:0]        wait_cnt;
    logic                     fail;
    logic signed [DATA_W-1:0] tol_q;
    logic signed [DATA_W-1:0] elem;
    logic                     elem_pass;

    // Single shared comparator: negative magnitudes are treated as failures.
    assign elem      = abs_flat[idx*DATA_W +: DATA_W];
    assign elem_pass = !elem[DATA_W-1] && (elem <= tol_q);

    always_ff @(posedge clk_conv) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples the pre-edge values; blocking would chain updates within one edge.
        if (rst_conv || clr) begin
            state     <= S_IDLE;
            idx       <= '0;
            wait_cnt  <= '0;
            fail      <= 1'b0;
            tol_q     <= '0;
            en_abs    <= 1'b0;
            busy      <= 1'b0;
            w_load    <= 1'b0;
            next_iter <= 1'b0;
            done      <= 1'b0;
            converged <= 1'b0;
            timeout   <= 1'b0;
            iter_cnt  <= '0;
            err_idx   <= '0;
        end else begin
            en_abs    <= 1'b0;
            w_load    <= 1'b0;
            next_iter <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_ABS;
                        tol_q  <= tol;
                        idx    <= '0;
                        fail   <= 1'b0;
                        en_abs <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                S_ABS: begin
                    state    <= S_WAIT;
                    wait_cnt <= WAIT_W'(ABS_LAT);
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == WAIT_W'(1))
                        state <= S_SCAN;
                end
                S_SCAN: begin
                    if (!elem_pass) begin
                        err_idx <= idx;
                        fail    <= 1'b1;
                        state   <= S_DECIDE;
                    end else if (idx == LAST_IDX) begin
                        err_idx <= '0;
                        fail    <= 1'b0;
                        state   <= S_DECIDE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DECIDE: begin
                    w_load <= 1'b1;
                    busy   <= 1'b0;
                    if (!fail) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        converged <= 1'b1;
                    end else if (iter_cnt == LAST_ITER) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        timeout  <= 1'b1;
                        iter_cnt <= ITER_W'(MAX_ITER);
                    end else begin
                        iter_cnt  <= iter_cnt + 1'b1;
                        next_iter <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_DONE: begin
                    // Results are held until clr or reset.
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fica_conv_ctrl.sv
// Self-checking bench for fica_conv_ctrl: a transaction-level timing model checked
// every cycle, plus directed runs with hand-computed latencies and results.
module tb_fica_conv_ctrl;

    localparam int DW   = 26;
    localparam int NE   = 16;
    localparam int LAT  = 1;
    localparam int MAXI = 4;
    localparam int IW   = 7;

    logic              clk_conv = 1'b0;
    logic              rst_conv = 1'b1;
    logic              start    = 1'b0;
    logic              clr      = 1'b0;
    logic [DW-1:0]     tol      = '0;
    logic [NE*DW-1:0]  abs_flat = '0;
    logic              en_abs, busy, w_load, next_iter, done, converged, timeout;
    logic [IW-1:0]     iter_cnt;
    logic [3:0]        err_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int en_abs_seen = 0;

    always #5 clk_conv = ~clk_conv;

    fica_conv_ctrl #(
        .DATA_W(DW), .N_ELEM(NE), .ABS_LAT(LAT), .MAX_ITER(MAXI), .ITER_W(IW)
    ) dut (
        .clk_conv(clk_conv), .rst_conv(rst_conv), .start(start), .clr(clr),
        .tol(tol), .abs_flat(abs_flat), .en_abs(en_abs), .busy(busy),
        .w_load(w_load), .next_iter(next_iter), .done(done), .converged(converged),
        .timeout(timeout), .iter_cnt(iter_cnt), .err_idx(err_idx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: on accept, work out how many elements the scan visits, then the
    // whole pass is a fixed timeline of 2 + LAT + s edges to the commit pulse.
    bit m_valid = 0, m_active = 0, m_fail = 0;
    bit m_en_abs = 0, m_busy = 0, m_w_load = 0, m_next_iter = 0;
    bit m_done = 0, m_conv = 0, m_to = 0;
    int m_iter = 0, m_err = 0, m_t = 0, m_lat = 0, m_fidx = 0;
    logic signed [DW-1:0] m_e;

    always @(posedge clk_conv) begin
        m_en_abs    = 0;
        m_w_load    = 0;
        m_next_iter = 0;
        if (rst_conv || clr) begin
            m_valid = 1; m_active = 0; m_busy = 0; m_done = 0; m_conv = 0;
            m_to = 0; m_iter = 0; m_err = 0; m_t = 0;
        end else if (m_active) begin
            m_t++;
            if (m_t == m_lat - 1)
                m_err = m_fail ? m_fidx : 0;
            if (m_t == m_lat) begin
                m_active = 0;
                m_busy   = 0;
                m_w_load = 1;
                if (!m_fail) begin
                    m_done = 1; m_conv = 1;
                end else if (m_iter == MAXI - 1) begin
                    m_done = 1; m_to = 1; m_iter = MAXI;
                end else begin
                    m_iter++; m_next_iter = 1;
                end
            end
        end else if (start && !m_done) begin
            m_fail = 0;
            m_fidx = 0;
            for (int k = NE - 1; k >= 0; k--) begin
                m_e = abs_flat[k*DW +: DW];
                if (m_e < 0 || m_e > $signed(tol)) begin
                    m_fail = 1;
                    m_fidx = k;
                end
            end
            m_lat    = 2 + LAT + (m_fail ? m_fidx + 1 : NE);
            m_t      = 0;
            m_active = 1;
            m_busy   = 1;
            m_en_abs = 1;
        end
    end

    always @(posedge clk_conv)
        if (en_abs === 1'b1) en_abs_seen++;

    always @(negedge clk_conv) begin
        if (m_valid) begin
            check("m_en_abs",    32'(en_abs),    32'(m_en_abs));
            check("m_busy",      32'(busy),      32'(m_busy));
            check("m_w_load",    32'(w_load),    32'(m_w_load));
            check("m_next_iter", 32'(next_iter), 32'(m_next_iter));
            check("m_done",      32'(done),      32'(m_done));
            check("m_converged", 32'(converged), 32'(m_conv));
            check("m_timeout",   32'(timeout),   32'(m_to));
            check("m_iter_cnt",  32'(iter_cnt),  m_iter);
            check("m_err_idx",   32'(err_idx),   m_err);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk_conv);
    endtask

    task automatic fill(input int v);
        for (int k = 0; k < NE; k++) abs_flat[k*DW +: DW] = DW'(v);
    endtask

    task automatic put(input int k, input int v);
        abs_flat[k*DW +: DW] = DW'(v);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    // One start pulse, then wait (bounded) for w_load; ends on the pulse cycle.
    task automatic run(input string name, input int exp_lat);
        int lat;
        int base;
        bit seen;
        base  = en_abs_seen;
        lat   = -1;
        seen  = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            if (w_load === 1'b1) begin
                seen = 1;
                lat  = c - 1;
            end else begin
                step();
            end
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_en_pulses"}, en_abs_seen - base, 1);
    endtask

    initial begin
        int base;
        int wl;
        tol = DW'(8);
        step(2);
        rst_conv = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_iter", 32'(iter_cnt), 0);

        // All-zero magnitudes converge after a full 16-element scan.
        fill(0);
        run("allzero", 19);
        check("allzero_done", 32'(done), 1);
        check("allzero_conv", 32'(converged), 1);
        check("allzero_iter", 32'(iter_cnt), 0);
        check("allzero_err", 32'(err_idx), 0);
        do_clr();
        check("clr_done", 32'(done), 0);

        // Element 5 over tolerance: early exit, another iteration requested.
        put(5, 9);
        run("e5", 9);
        check("e5_next_iter", 32'(next_iter), 1);
        check("e5_iter", 32'(iter_cnt), 1);
        check("e5_err", 32'(err_idx), 5);
        check("e5_done", 32'(done), 0);
        check("e5_busy", 32'(busy), 0);
        step();
        check("e5_wload_once", 32'(w_load), 0);
        do_clr();

        // Equality with tolerance passes; a negative magnitude fails.
        fill(8);
        run("eq", 19);
        check("eq_conv", 32'(converged), 1);
        do_clr();
        put(15, -1);
        run("neg", 19);
        check("neg_err", 32'(err_idx), 15);
        check("neg_next_iter", 32'(next_iter), 1);
        check("neg_conv", 32'(converged), 0);
        do_clr();

        // Timeout after MAXI failing passes.
        fill(0);
        put(0, 100);
        for (int i = 0; i < MAXI - 1; i++) begin
            run("to_pass", 4);
            check("to_next_iter", 32'(next_iter), 1);
            check("to_iter", 32'(iter_cnt), i + 1);
        end
        run("to_last", 4);
        check("to_done", 32'(done), 1);
        check("to_timeout", 32'(timeout), 1);
        check("to_conv", 32'(converged), 0);
        check("to_iter_final", 32'(iter_cnt), 4);
        check("to_last_next", 32'(next_iter), 0);
        base = en_abs_seen;
        start = 1'b1;
        step();
        start = 1'b0;
        check("ignored_busy", 32'(busy), 0);
        step(3);
        check("ignored_en", en_abs_seen - base, 0);
        check("ignored_done", 32'(done), 1);
        do_clr();

        // start held high through a converging pass gives one en_abs pulse.
        fill(0);
        base = en_abs_seen;
        start = 1'b1;
        step(25);
        start = 1'b0;
        check("held_en", en_abs_seen - base, 1);
        check("held_conv", 32'(converged), 1);
        do_clr();

        // clr in the middle of a scan aborts with no commit.
        put(2, 50);
        run("pre", 6);
        check("pre_iter", 32'(iter_cnt), 1);
        step();
        fill(0);
        start = 1'b1;
        step();
        start = 1'b0;
        step(4);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_iter", 32'(iter_cnt), 0);
        check("abort_err", 32'(err_idx), 0);
        wl = 0;
        for (int c = 0; c < 20; c++) begin
            if (w_load === 1'b1) wl++;
            step();
        end
        check("abort_no_wload", wl, 0);

        // Reset during WAIT after three failing passes.
        put(0, 100);
        for (int i = 0; i < 3; i++) run("rw_pass", 4);
        check("rw_iter", 32'(iter_cnt), 3);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("rw_abs_en", 32'(en_abs), 1);
        step();
        check("rw_wait_busy", 32'(busy), 1);
        rst_conv = 1'b1;
        step();
        rst_conv = 1'b0;
        check("rw_busy", 32'(busy), 0);
        check("rw_iter0", 32'(iter_cnt), 0);
        check("rw_en", 32'(en_abs), 0);
        fill(0);
        run("post", 19);
        check("post_conv", 32'(converged), 1);
        check("post_iter", 32'(iter_cnt), 0);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fica_conv_ctrl.md
Name: fica_conv_ctrl

Overview:
- Convergence controller for the FastICA weight-update loop.
- Each time the update stage presents a new W matrix, it pulses the error-abs stage enable, waits for the 16 registered |w_new - w_old| magnitudes, and scans them serially through one shared comparator against a tolerance.
- It then commits W and either requests another iteration or declares the run converged or timed out.
- It sits between the W-update stage, the error-abs datapath and the top-level sequencer.

Parameters:
- DATA_W, 26, element width (signed Q12.13 fixed point).
- N_ELEM, 16, number of matrix elements scanned (4x4).
- ABS_LAT, 1, cycles from en_abs high to valid abs outputs.
- MAX_ITER, 64, maximum iterations before timeout.
- ITER_W, 7, iteration counter width; must satisfy 2^ITER_W > MAX_ITER.

Ports:
- clk_conv  in  1  clock.
- rst_conv  in  1  synchronous, active-high reset.
- start  in  1  new w_new valid; accepted only in IDLE.
- clr  in  1  begin a new run; zeroes iter_cnt and flags.
- tol  in  DATA_W  convergence tolerance (Q13, non-negative); sampled on accepted start.
- abs_flat  in  N_ELEM*DATA_W  abs outputs, row-major; element k at [26k+25:26k] (k=0 is row1/col1, k=15 is row4/col4).
- en_abs  out  1  enable for error-abs stage.
- busy  out  1  high in every state except IDLE and DONE.
- w_load  out  1  one-cycle pulse: commit w_new as w_old.
- next_iter  out  1  one-cycle pulse: launch the next W update.
- done  out  1  level; run finished.
- converged  out  1  valid while done.
- timeout  out  1  valid while done.
- iter_cnt  out  ITER_W  completed non-converged iterations in this run.
- err_idx  out  4  index of the first failing element in the last scan; 0 if none failed.

Behaviour:
- Reset (rst_conv=1 at an edge), from any state including mid-scan:
  - state=IDLE.
  - All outputs 0: en_abs, busy, w_load, next_iter, done, converged, timeout, iter_cnt, err_idx.
  - Internal index, wait counter and fail flag 0.
- clr:
  - Same effect as reset, from any state, except it has lower priority than rst_conv.
  - An in-flight scan is aborted and no pulses are emitted.
- States: IDLE, ABS, WAIT, SCAN, DECIDE, DONE.
- IDLE:
  - start=1 → ABS; latch tol; idx=0; fail=0.
  - start is ignored in every other state, with no queuing.
- ABS: en_abs=1 for exactly this one cycle → WAIT with wait counter = ABS_LAT.
- WAIT: decrement the counter each cycle; move to SCAN on the cycle it reaches 0.
- SCAN: one element per cycle. Element e = abs_flat[idx].
  - e is treated as signed.
  - Pass iff 0 <= e <= tol (equality passes). Negative e fails.
  - On fail: err_idx=idx, fail=1 → DECIDE (early exit).
  - On pass with idx==N_ELEM-1 → DECIDE with fail=0, err_idx=0.
  - Otherwise idx++.
- DECIDE (single cycle; w_load=1 in all branches):
  - fail=0: → DONE; converged=1.
  - fail=1 and iter_cnt==MAX_ITER-1: → DONE; timeout=1; iter_cnt=MAX_ITER.
  - fail=1 otherwise: iter_cnt++; next_iter=1; → IDLE.
- DONE: done=1 and converged/timeout are held until clr or reset; start is ignored.
- Outputs are registered. Pulses (w_load, next_iter) are visible in the cycle after the DECIDE edge, for one cycle only.
- Latency from the start-accept edge to the w_load pulse is 2 + ABS_LAT + s cycles, where s = number of elements scanned (1..16).
  - Best case (idx0 fails): 4 cycles.
  - All-pass case: 19 cycles.
- abs_flat must be stable from the end of WAIT through SCAN; the error-abs stage holds its registers when en_abs=0 and no new start is applied.

Decomposition:
- Package fica_pkg holds:
  - constants DATA_W=26, FRAC_W=13, N_ELEM=16;
  - the state enum conv_state_t;
  - typedef fx_t = signed [DATA_W-1:0].
- No sub-module: the 16:1 element select plus single comparator stays inline. The scan mux is a simple indexed part-select.

Test Plan:
- All 16 elements = 0, tol=8, start → en_abs high in 1 cycle only; w_load at cycle 19; done=1, converged=1, iter_cnt=0, err_idx=0.
- Element 5 = 9, others 0, tol=8 → scan stops at idx5; w_load and next_iter pulse at cycle 9; state IDLE, iter_cnt=1, err_idx=5, done=0.
- All elements = 8, tol=8 → converged (boundary equality passes). Repeat with element 15 = -1 → fail, err_idx=15.
- MAX_ITER=4, element 0 = 100 on every start, 4 starts → next_iter pulses 3 times; 4th ends DONE with timeout=1, converged=0, iter_cnt=4. A 5th start is ignored (busy stays 0, no en_abs).
- start held high throughout a scan → only one en_abs pulse per pass. clr asserted mid-SCAN → next cycle IDLE, no w_load, iter_cnt=0.
- rst_conv asserted in WAIT with iter_cnt=3 → all outputs 0 next cycle. A following start completes normally with converged=1.
